// File: rtl/register_file_if.sv
// ---------------------------------------------------------------------------
// register_file_if
// Bus bundle for the multi-ported register file.
//   select_a_i[3:0]   read selects for the four A ports
//   select_b_i[3:0]   read selects for the four B ports
//   select_c_i[1:0]   read selects for the two C ports
//   select_r_i[3:0]   write selects for the four write ports
//   data_i[3:0]       write data for the four write ports
//   enable_writing_i  per-write-port enable (bit n -> write port n)
//   a_o, b_o, c_o     read data for the A, B and C ports
//   ip_o              live content of the instruction-pointer register
// master : drives selects/data/enables, consumes read data
// slave  : the register file itself
// ---------------------------------------------------------------------------
interface register_file_if #(
   parameter int WORD_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
);
   logic [3:0][ADDRESS_WIDTH-1:0] select_a_i;
   logic [3:0][ADDRESS_WIDTH-1:0] select_b_i;
   logic [1:0][ADDRESS_WIDTH-1:0] select_c_i;
   logic [3:0][ADDRESS_WIDTH-1:0] select_r_i;
   logic [3:0][WORD_WIDTH-1:0]    data_i;
   logic [3:0]                    enable_writing_i;
   logic [3:0][WORD_WIDTH-1:0]    a_o;
   logic [3:0][WORD_WIDTH-1:0]    b_o;
   logic [1:0][WORD_WIDTH-1:0]    c_o;
   logic [WORD_WIDTH-1:0]         ip_o;

   modport master (
      output select_a_i, select_b_i, select_c_i, select_r_i, data_i, enable_writing_i,
      input  a_o, b_o, c_o, ip_o
   );

   modport slave (
      input  select_a_i, select_b_i, select_c_i, select_r_i, data_i, enable_writing_i,
      output a_o, b_o, c_o, ip_o
   );
endinterface

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 2^ADDRESS_WIDTH x WORD_WIDTH register file with ten combinational read
// ports (4 A, 4 B, 2 C), four write ports and a dedicated instruction-pointer
// tap.
//   clk_i   sole clock, all state changes on its rising edge
//   arst_i  synchronous active-low reset: clears every register and
//           suppresses all writes of that cycle
//   rf      register_file_if slave modport (selects, data, enables, reads)
// Reads show pre-edge content; there is no write-to-read bypass.
// Same-address writes in one cycle resolve with the highest port winning.
// ---------------------------------------------------------------------------
module register_file #(
   parameter int WORD_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int IP_OFFSET     = 2
) (
   input  logic           clk_i,
   input  logic           arst_i,
   register_file_if.slave rf
);
   localparam int NUM_REGS  = 1 << ADDRESS_WIDTH;
   localparam int NUM_WPORT = 4;
   localparam logic [ADDRESS_WIDTH-1:0] IP_SEL = ADDRESS_WIDTH'(IP_OFFSET);

   logic [WORD_WIDTH-1:0] regs_r      [NUM_REGS];
   logic [WORD_WIDTH-1:0] regs_next_s [NUM_REGS];
   logic [NUM_WPORT-1:0]  write_hit_s [NUM_REGS];

   // Decode which enabled write ports target each register.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         write_hit_s[i] = 4'b0000;
         for (int p = 0; p < NUM_WPORT; p++) begin
            write_hit_s[i][p] = rf.enable_writing_i[p] &&
                                (rf.select_r_i[p] == ADDRESS_WIDTH'(i));
         end
      end
   end

   // Merge writes per register; ports are folded in ascending order so the
   // highest-index hitting port is the last to override.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_next_s[i] = regs_r[i];
         for (int p = 0; p < NUM_WPORT; p++) begin
            regs_next_s[i] = write_hit_s[i][p] ? rf.data_i[p] : regs_next_s[i];
         end
      end
   end

   // Register storage: reset clears everything and wins over any write.
   always_ff @(posedge clk_i) begin
      if (!arst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= regs_next_s[i];
         end
      end
   end

   // A and B read ports: pure muxes off the stored state.
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         rf.a_o[p] = regs_r[rf.select_a_i[p]];
         rf.b_o[p] = regs_r[rf.select_b_i[p]];
      end
   end

   // C read ports and the instruction-pointer tap.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rf.c_o[p] = regs_r[rf.select_c_i[p]];
      end
      rf.ip_o = regs_r[IP_SEL];
   end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Table of write/read vectors with hand-derived A-port expectations; B/C/ip
// expectations come from a reference array. Expected records are queued when
// a cycle is driven and popped after the edge that commits it. Hand-written
// sequences cover the no-bypass window and a mid-operation reset.
// ---------------------------------------------------------------------------
module tb_register_file;
   localparam int WW = 32;
   localparam int AW = 5;
   localparam int NR = 1 << AW;
   localparam int IP = 2;

   logic clk;
   logic arst;

   register_file_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) rf_bus ();

   register_file #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .IP_OFFSET(IP)) dut (
      .clk_i  (clk),
      .arst_i (arst),
      .rf     (rf_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic                  rst_n;
      logic [3:0]            en;
      logic [3:0][AW-1:0]    sel_r;
      logic [3:0][WW-1:0]    data;
      logic [3:0][AW-1:0]    sel_a;
      logic [3:0][WW-1:0]    exp_a;
   } vec_t;

   typedef struct {
      logic [3:0][WW-1:0] a;
      logic [3:0][WW-1:0] b;
      logic [1:0][WW-1:0] c;
      logic [WW-1:0]      ip;
   } exp_t;

   logic [WW-1:0] model [NR];
   exp_t          sb_q [$];
   int            n_pass = 0;
   int            n_total = 0;

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Reference update: ports applied in order so port 3 has the final say.
   task automatic model_step(input logic rst_n, input logic [3:0] en,
                             input logic [3:0][AW-1:0] sel_r, input logic [3:0][WW-1:0] data);
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) model[i] = '0;
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (en[p]) model[sel_r[p]] = data[p];
         end
      end
   endtask

   // Drive one cycle, queue its expectation, then compare after the edge.
   task automatic run_cycle(input string tag, input logic rst_n, input logic [3:0] en,
                            input logic [3:0][AW-1:0] sel_r, input logic [3:0][WW-1:0] data,
                            input logic [3:0][AW-1:0] sel_a, input logic [3:0][WW-1:0] exp_a,
                            input bit a_from_model);
      exp_t e;
      exp_t got;
      @(negedge clk);
      arst = rst_n;
      rf_bus.enable_writing_i = en;
      rf_bus.select_r_i = sel_r;
      rf_bus.data_i = data;
      rf_bus.select_a_i = sel_a;
      for (int p = 0; p < 4; p++) rf_bus.select_b_i[p] = AW'($urandom_range(NR - 1, 0));
      for (int p = 0; p < 2; p++) rf_bus.select_c_i[p] = AW'($urandom_range(NR - 1, 0));
      model_step(rst_n, en, sel_r, data);
      for (int p = 0; p < 4; p++) begin
         e.a[p] = a_from_model ? model[sel_a[p]] : exp_a[p];
         e.b[p] = model[rf_bus.select_b_i[p]];
      end
      for (int p = 0; p < 2; p++) e.c[p] = model[rf_bus.select_c_i[p]];
      e.ip = model[IP];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      for (int p = 0; p < 4; p++) check($sformatf("%s a_o[%0d]", tag, p), rf_bus.a_o[p], got.a[p]);
      for (int p = 0; p < 4; p++) check($sformatf("%s b_o[%0d]", tag, p), rf_bus.b_o[p], got.b[p]);
      for (int p = 0; p < 2; p++) check($sformatf("%s c_o[%0d]", tag, p), rf_bus.c_o[p], got.c[p]);
      check($sformatf("%s ip_o", tag), rf_bus.ip_o, got.ip);
   endtask

   function automatic logic [3:0][AW-1:0] s4(input int s3, input int s2, input int s1, input int s0);
      logic [3:0][AW-1:0] r;
      r[3] = AW'(s3); r[2] = AW'(s2); r[1] = AW'(s1); r[0] = AW'(s0);
      return r;
   endfunction

   function automatic logic [3:0][WW-1:0] d4(input logic [WW-1:0] d3, input logic [WW-1:0] d2,
                                             input logic [WW-1:0] d1, input logic [WW-1:0] d0);
      logic [3:0][WW-1:0] r;
      r[3] = d3; r[2] = d2; r[1] = d1; r[0] = d0;
      return r;
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vecs [10];
      logic [3:0][AW-1:0] sr;
      logic [3:0][WW-1:0] dd;
      logic [3:0]         ee;

      arst = 1'b0;
      rf_bus.enable_writing_i = 4'b0000;
      rf_bus.select_a_i = '0;
      rf_bus.select_b_i = '0;
      rf_bus.select_c_i = '0;
      rf_bus.select_r_i = '0;
      rf_bus.data_i = '0;
      for (int i = 0; i < NR; i++) model[i] = '0;

      // rst_n, en, sel_r, data, sel_a, expected a_o
      vecs[0] = '{1'b0, 4'b0000, s4(0,0,0,0), d4(32'd0,32'd0,32'd0,32'd0),
                  s4(3,2,1,0), d4(32'd0,32'd0,32'd0,32'd0)};
      vecs[1] = '{1'b1, 4'b1111, s4(3,2,1,0), d4(32'd3,32'd2,32'd1,32'd0),
                  s4(3,2,1,0), d4(32'd3,32'd2,32'd1,32'd0)};
      vecs[2] = '{1'b1, 4'b0001, s4(9,9,9,0), d4(32'd99,32'd99,32'd99,32'd4),
                  s4(3,2,1,0), d4(32'd3,32'd2,32'd1,32'd4)};
      vecs[3] = '{1'b1, 4'b1111, s4(5,5,5,5), d4(32'd40,32'd30,32'd20,32'd10),
                  s4(5,5,5,5), d4(32'd40,32'd40,32'd40,32'd40)};
      vecs[4] = '{1'b1, 4'b0100, s4(6,2,6,6), d4(32'd7,32'h1234,32'd7,32'd7),
                  s4(2,2,2,2), d4(32'h1234,32'h1234,32'h1234,32'h1234)};
      vecs[5] = '{1'b1, 4'b0000, s4(3,2,1,0), d4(32'hFFFF_FFFF,32'hFFFF_FFFF,32'hFFFF_FFFF,32'hFFFF_FFFF),
                  s4(3,2,1,0), d4(32'd3,32'h1234,32'd1,32'd4)};
      vecs[6] = '{1'b1, 4'b1010, s4(8,2,7,2), d4(32'h88,32'hBAD,32'h77,32'hBAD),
                  s4(8,7,5,2), d4(32'h88,32'h77,32'd40,32'h1234)};
      vecs[7] = '{1'b0, 4'b1111, s4(8,7,5,2), d4(32'h11,32'h22,32'h33,32'h44),
                  s4(8,7,5,2), d4(32'd0,32'd0,32'd0,32'd0)};
      vecs[8] = '{1'b1, 4'b0000, s4(1,1,1,1), d4(32'h5,32'h5,32'h5,32'h5),
                  s4(3,2,1,0), d4(32'd0,32'd0,32'd0,32'd0)};
      vecs[9] = '{1'b1, 4'b0011, s4(4,4,31,31), d4(32'h1,32'h1,32'hBEEF,32'hDEAD),
                  s4(31,31,0,0), d4(32'hBEEF,32'hBEEF,32'd0,32'd0)};

      for (int v = 0; v < 10; v++) begin
         run_cycle($sformatf("vec%0d", v), vecs[v].rst_n, vecs[v].en, vecs[v].sel_r,
                   vecs[v].data, vecs[v].sel_a, vecs[v].exp_a, 1'b0);
      end

      // Reload known content for the corner sequences.
      run_cycle("load", 1'b1, 4'b1111, s4(3,2,1,0),
                d4(32'hA3,32'hA2,32'hA1,32'hA0), s4(3,2,1,0), '0, 1'b1);

      // No bypass: new data must not appear before the committing edge.
      @(negedge clk);
      arst = 1'b1;
      rf_bus.enable_writing_i = 4'b0001;
      rf_bus.select_r_i = s4(0,0,0,3);
      rf_bus.data_i = d4(32'd0,32'd0,32'd0,32'hAAAA);
      rf_bus.select_a_i = s4(3,3,3,3);
      #1;
      check("nobypass pre-edge a_o[0]", rf_bus.a_o[0], 32'hA3);
      model[3] = 32'hAAAA;
      @(posedge clk);
      #1;
      check("nobypass post-edge a_o[0]", rf_bus.a_o[0], 32'hAAAA);

      // Mid-operation reset: outputs hold until the edge, then clear; writes dropped.
      @(negedge clk);
      arst = 1'b0;
      rf_bus.enable_writing_i = 4'b1111;
      rf_bus.select_r_i = s4(3,2,1,0);
      rf_bus.data_i = d4(32'h55,32'h55,32'h55,32'h55);
      rf_bus.select_a_i = s4(3,2,1,0);
      #1;
      check("midrst pre-edge a_o[3]", rf_bus.a_o[3], 32'hAAAA);
      check("midrst pre-edge ip_o", rf_bus.ip_o, 32'hA2);
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) model[i] = '0;
      check("midrst post-edge a_o[3]", rf_bus.a_o[3], 32'd0);
      check("midrst post-edge a_o[0]", rf_bus.a_o[0], 32'd0);
      check("midrst post-edge ip_o", rf_bus.ip_o, 32'd0);

      // Randomised traffic with frequent address collisions.
      for (int k = 0; k < 40; k++) begin
         for (int p = 0; p < 4; p++) begin
            sr[p] = AW'($urandom_range(7, 0));
            dd[p] = $urandom;
         end
         ee = 4'($urandom_range(15, 0));
         run_cycle($sformatf("rnd%0d", k), 1'b1, ee, sr, dd,
                   s4($urandom_range(7,0), $urandom_range(7,0), $urandom_range(7,0), IP),
                   '0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
